// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with byte-lane writes,
// programmable wait states and the two-cycle ERROR response.
//
// Ports:
//   hclk, hreset       clock, async active-high reset
//   hsel, haddr        select and byte address (address phase)
//   htrans, hwrite     transfer type and direction (address phase)
//   hsize              0 byte, 1 halfword, 2 word (address phase)
//   hwdata             write data (data phase)
//   hready             bus-level ready
//   hreadyout, hresp   this slave's ready and response
//   hrdata             read data, zero outside a completing read
module ahb_sram_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic          write_q, write_d;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          illegal;
    logic          hi_bad;
    logic          last;
    logic [3:0]    be_new;
    logic          unused_htrans;

    assign unused_htrans = htrans[0];

    // Final cycle of an OKAY data phase.
    assign last = (state_q == S_DATA) && (cnt_q == 4'd0);

    assign hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2) || last;
    assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign hrdata    = (last && !write_q) ? mem[addr_q] : 32'd0;

    // Only sample a new address phase in cycles where we report ready,
    // so a stalled or erroring data phase can never be overrun.
    assign accept = hsel && hready && htrans[1] && hreadyout;

    // Any set address bit at or above DEPTH*4 means out of range.
    assign hi_bad  = |(haddr >> (IW + 2));
    assign illegal = (hsize > 3'd2)
                   || (hsize == 3'd1 && haddr[0])
                   || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                   || hi_bad;

    always_comb begin
        be_new = 4'b1111;
        unique case (hsize[1:0])
            2'd0:    be_new = 4'b0001 << haddr[1:0];
            2'd1:    be_new = haddr[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        write_d = write_q;
        if (hreadyout) begin
            if (accept) begin
                addr_d  = haddr[IW+1:2];
                be_d    = be_new;
                write_d = hwrite;
                cnt_d   = WS;
                state_d = illegal ? S_ERR1 : S_DATA;
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_DATA) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            state_d = S_ERR2;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            write_q <= write_d;
        end
    end

    // Memory is never reset; a reset forces IDLE so no commit follows.
    always_ff @(posedge hclk) begin
        if (last && write_q && !hreset) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[addr_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: pipelined master, byte-lane memory
// model and an expectation queue popped as each data phase completes.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'd0;
    logic        hold_lo = 1'b0;
    logic        use3 = 1'b0;
    logic        hready;

    logic        ro0, rs0, ro3, rs3;
    logic [31:0] rd0, rd3;
    logic        ro, rs;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    assign ro     = use3 ? ro3 : ro0;
    assign rs     = use3 ? rs3 : rs0;
    assign rd     = use3 ? rd3 : rd0;
    assign hready = ~hold_lo & ro;

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0), .ADDR_WIDTH(32)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & ~use3),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hready(hready),
        .hreadyout(ro0), .hresp(rs0), .hrdata(rd0)
    );

    ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(3), .ADDR_WIDTH(32)) dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel & use3),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hwdata(hwdata), .hready(hready),
        .hreadyout(ro3), .hresp(rs3), .hrdata(rd3)
    );

    typedef struct {
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
    } xfer_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          waits;
    } exp_t;

    xfer_t       iss[$];
    exp_t        sb[$];
    logic [31:0] mm [2][256];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(logic [1:0] tr, logic wr, logic [2:0] sz,
                       logic [31:0] a, logic [31:0] wd);
        xfer_t x;
        x.tr = tr; x.wr = wr; x.sz = sz; x.a = a; x.wd = wd;
        iss.push_back(x);
    endtask

    function automatic bit bad(xfer_t x);
        return (x.sz > 3'd2) || (x.sz == 3'd1 && x.a[0])
            || (x.sz == 3'd2 && x.a[1:0] != 2'b00) || (x.a >= 32'd1024);
    endfunction

    // Present the next address phase and record what its data phase must show.
    task automatic drive_next(output bit v, output logic [31:0] wd);
        xfer_t x;
        exp_t  e;
        int    w;
        bit    en;
        wd = 32'hDEAD_0000;
        if (iss.size() == 0) begin
            v = 1'b0;
            hsel = 1'b0; htrans = 2'b00; haddr = 32'd0;
            hwrite = 1'b0; hsize = 3'd0;
            return;
        end
        x = iss.pop_front();
        v = 1'b1;
        wd = x.wd;
        hsel = 1'b1; htrans = x.tr; haddr = x.a;
        hwrite = x.wr; hsize = x.sz;
        e.err = 1'b0; e.rd = 32'd0; e.waits = 0;
        if (x.tr[1]) begin
            if (bad(x)) begin
                e.err = 1'b1;
                e.waits = 1;
            end else begin
                w = int'(x.a[9:2]);
                e.waits = use3 ? 3 : 0;
                if (x.wr) begin
                    for (int k = 0; k < 4; k++) begin
                        en = (x.sz == 3'd2)
                          || (x.sz == 3'd1 && (k / 2) == int'(x.a[1]))
                          || (x.sz == 3'd0 && k == int'(x.a[1:0]));
                        if (en) mm[use3][w][8*k +: 8] = x.wd[8*k +: 8];
                    end
                end else begin
                    e.rd = mm[use3][w];
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic run();
        bit          av, dv, rdy;
        logic [31:0] awd;
        int          waits, cyc;
        exp_t        e;
        dv = 1'b0; waits = 0; cyc = 0;
        @(posedge hclk); #1;
        drive_next(av, awd);
        while (av || dv) begin
            @(negedge hclk);
            rdy = hready;
            if (dv) begin
                if (ro) begin
                    e = sb.pop_front();
                    chk("hresp", 32'(rs), 32'(e.err));
                    chk("hrdata", rd, e.rd);
                    chk("waits", 32'(waits), 32'(e.waits));
                end else begin
                    waits++;
                    chk("wait_hrdata", rd, 32'd0);
                    chk("wait_hresp", 32'(rs), 32'(sb[0].err));
                end
            end
            @(posedge hclk); #1;
            if (rdy) begin
                dv = av;
                waits = 0;
                hwdata = awd;
                drive_next(av, awd);
            end
            cyc++;
            if (cyc > 300) begin
                checks++;
                errors++;
                $display("FAIL timeout observed=stall expected=completion");
                iss.delete();
                sb.delete();
                hsel = 1'b0; htrans = 2'b00;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mm[0][i] = 32'd0;
            mm[1][i] = 32'd0;
        end

        // Reset values on both instances
        #3;
        chk("rst_ro0", 32'(ro0), 32'd1);
        chk("rst_rs0", 32'(rs0), 32'd0);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_ro3", 32'(ro3), 32'd1);
        chk("rst_rs3", 32'(rs3), 32'd0);
        chk("rst_rd3", rd3, 32'd0);
        repeat (2) @(posedge hclk);
        #2 hreset = 1'b0;

        // Zero wait: write then read, one cycle each
        use3 = 1'b0;
        add(2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        add(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        run();

        // Byte and halfword lanes
        add(2'b10, 1'b1, 3'd2, 32'h10, 32'h11223344);
        add(2'b10, 1'b1, 3'd0, 32'h13, {4{8'hAA}});
        add(2'b10, 1'b1, 3'd1, 32'h10, {2{16'h5566}});
        add(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
        add(2'b10, 1'b1, 3'd0, 32'h16, {4{8'h7E}});
        add(2'b10, 1'b1, 3'd1, 32'h16, {2{16'hBEEF}});
        add(2'b10, 1'b0, 3'd2, 32'h14, 32'h0);
        run();

        // Illegal accesses leave memory untouched
        add(2'b10, 1'b1, 3'd2, 32'h00, 32'hCAFEF00D);
        add(2'b10, 1'b1, 3'd1, 32'h01, 32'hFFFFFFFF);
        add(2'b10, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF);
        add(2'b10, 1'b0, 3'd3, 32'h00, 32'h0);
        add(2'b10, 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF);
        add(2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
        add(2'b10, 1'b1, 3'd2, 32'h3FC, 32'h0F0F0F0F);
        add(2'b10, 1'b0, 3'd2, 32'h3FC, 32'h0);
        run();

        // Pipelined burst, then IDLE/BUSY that must not write
        add(2'b10, 1'b1, 3'd2, 32'h20, 32'hA0A0A0A0);
        add(2'b11, 1'b1, 3'd2, 32'h24, 32'hA1A1A1A1);
        add(2'b11, 1'b1, 3'd2, 32'h28, 32'hA2A2A2A2);
        add(2'b11, 1'b1, 3'd2, 32'h2C, 32'hA3A3A3A3);
        add(2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        add(2'b11, 1'b0, 3'd2, 32'h24, 32'h0);
        add(2'b11, 1'b0, 3'd2, 32'h28, 32'h0);
        add(2'b11, 1'b0, 3'd2, 32'h2C, 32'h0);
        add(2'b00, 1'b1, 3'd2, 32'h20, 32'h55555555);
        add(2'b01, 1'b1, 3'd2, 32'h24, 32'h66666666);
        add(2'b10, 1'b0, 3'd2, 32'h20, 32'h0);
        add(2'b01, 1'b1, 3'd2, 32'h28, 32'h77777777);
        add(2'b11, 1'b0, 3'd2, 32'h24, 32'h0);
        run();

        // Three wait states, errors, read-after-write
        use3 = 1'b1;
        add(2'b10, 1'b1, 3'd2, 32'h04, 32'h0BADCAFE);
        add(2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
        add(2'b10, 1'b1, 3'd1, 32'h03, 32'hFFFFFFFF);
        add(2'b10, 1'b1, 3'd2, 32'h40, 32'h12345678);
        add(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
        run();

        // hready low while idle: no acceptance
        @(posedge hclk); #1;
        hold_lo = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h04; hwdata = 32'h0;
        @(posedge hclk); #1;
        hold_lo = 1'b0; hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        chk("hrdy_lo_ro", 32'(ro), 32'd1);
        chk("hrdy_lo_rs", 32'(rs), 32'd0);
        chk("hrdy_lo_rd", rd, 32'd0);

        // Reset during the second wait cycle of a write
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h40;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
        chk("mid_wait1_ro", 32'(ro), 32'd0);
        @(posedge hclk); #1;
        chk("mid_wait2_ro", 32'(ro), 32'd0);
        hreset = 1'b1;
        #1;
        chk("mid_rst_ro", 32'(ro), 32'd1);
        chk("mid_rst_rs", 32'(rs), 32'd0);
        chk("mid_rst_rd", rd, 32'd0);
        repeat (2) @(posedge hclk);
        #2 hreset = 1'b0;
        add(2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
        add(2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
        run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (slave) with a word-organised internal SRAM. It sits behind the address decoder (hsel) and feeds the read-data multiplexer (hrdata, hreadyout, hresp).
- Completes master-initiated reads and writes with a configurable number of wait states.
- Supports byte, halfword and word accesses with byte-lane writes.
- Returns the two-cycle AHB ERROR response for illegal accesses.

Parameters:
- DEPTH, 256, number of 32-bit words in the SRAM (power of two, 16..4096).
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15).
- ADDR_WIDTH, 32, width of haddr.

Ports:
- hclk  in  1  bus clock; all logic is on the rising edge.
- hreset  in  1  asynchronous, active-high reset.
- hsel  in  1  slave select from the address decoder.
- haddr  in  ADDR_WIDTH  byte address. Only the bits below log2(DEPTH)+2 index the SRAM; higher bits are checked for range.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  000 byte, 001 halfword, 010 word; any larger value is illegal.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready (the muxed hreadyout of the addressed slave).
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset (async, hreset=1):
  - State goes to IDLE. hreadyout=1, hresp=0, hrdata=0.
  - Latched address-phase registers are cleared. SRAM contents are not cleared.
  - A reset in the middle of a transfer abandons it, and no SRAM write occurs.
- Address-phase acceptance:
  - A transfer is accepted on an edge where hsel=1, hready=1 and htrans[1]=1.
  - On acceptance, latch haddr, hsize and hwrite.
  - IDLE or BUSY while selected, or hsel=0: nothing is latched. The next cycle is IDLE with an OKAY, zero-wait response.
- Legality check at acceptance. A transfer is illegal if any of these holds:
  - hsize>2;
  - hsize=1 with haddr[0]=1;
  - hsize=2 with haddr[1:0]!=0;
  - haddr >= DEPTH*4.
- States:
  - IDLE: hreadyout=1, hresp=0. A legal transfer goes to DATA with cnt=WAIT_STATES. An illegal transfer goes to ERR1.
  - DATA: hreadyout = (cnt==0), hresp=0. cnt decrements each cycle while nonzero.
    - When cnt==0, the cycle completes the data phase.
    - If a new transfer is accepted in that cycle (hready=1), the next state is DATA (cnt reloaded) or ERR1. Otherwise the next state is IDLE.
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1.
    - A transfer accepted in this cycle is handled exactly as from IDLE.
    - If the master drives IDLE (cancelling), the next state is IDLE.
- Writes:
  - Committed on the edge that ends the completing DATA cycle (cnt==0), using hwdata sampled on that edge.
  - Byte lanes are little-endian:
    - byte: lane haddr[1:0];
    - halfword: lanes {haddr[1],0} and {haddr[1],1};
    - word: all four lanes.
  - Other lanes are unchanged. Illegal transfers never write.
- Reads:
  - hrdata = the full 32-bit word mem[addr_q] during the completing DATA cycle of a read. hrdata is 0 in every other cycle.
  - The SRAM is read combinationally from the latched address.
  - The master extracts the byte lanes it needs.
- Read-after-write: a read whose data phase directly follows a write data phase to the same word returns the newly written data, because the write commits at the boundary edge.
- Back-to-back pipelining: with WAIT_STATES=0, consecutive NONSEQ/SEQ transfers complete one per cycle with no bubbles.
- hready=0 while this slave is idle (another slave is stalling): no acceptance, and outputs hold IDLE values.

Test Plan:
- Reset, then WAIT_STATES=0: word write 0xDEADBEEF at 0x10, then word read at 0x10 -> read data phase has hreadyout=1, hrdata=0xDEADBEEF, hresp=0, one cycle per transfer.
- WAIT_STATES=3: word read at 0x04 -> hreadyout low for exactly 3 cycles, then high with data; hrdata=0 during the wait cycles.
- Byte write 0xAA at 0x13 over 0x11223344, then halfword write 0x5566 at 0x10, then word read 0x10 -> 0xAA225566.
- Halfword at 0x01, word at 0x02, hsize=3, and address DEPTH*4 -> each gets ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); a follow-up read confirms memory is unchanged.
- Pipelined burst: 4 SEQ word writes to 0x20..0x2C, then 4 reads -> no stall cycles, correct data; IDLE/BUSY interleaved -> OKAY zero-wait responses and no writes.
- Assert hreset during the second wait cycle of a write with WAIT_STATES=3 -> outputs go immediately to hreadyout=1, hresp=0, hrdata=0; the target word is unchanged.
